// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - memory-side handshake between the control unit and instruction/data memory
interface multicycle_control_if;
   logic [31:0] Instruction;
   logic        Mem_Ready;
   logic        Mem_Req;
   logic        Mem_Write;

   modport master (input Instruction, input Mem_Ready, output Mem_Req, output Mem_Write);
   modport slave  (output Instruction, output Mem_Ready, input Mem_Req, input Mem_Write);
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory waits, MUL latency, trap and retire counter
module multicycle_control #(
   parameter logic [5:0] OP_RTYPE   = 6'b010001,
   parameter logic [5:0] OP_LW      = 6'b010010,
   parameter logic [5:0] OP_SW      = 6'b010011,
   parameter logic [5:0] FN_ADD     = 6'b100000,
   parameter logic [5:0] FN_SUB     = 6'b100010,
   parameter logic [5:0] FN_MUL     = 6'b110010,
   parameter int         MUL_CYCLES = 4,
   parameter int         CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   multicycle_control_if.master mem,
   output logic             IR_Write,
   output logic             PC_Write,
   output logic [2:0]       ALU_Op,
   output logic             ALU_SrcB,
   output logic             RegDst,
   output logic             MemToReg,
   output logic             Reg_Write,
   output logic             Mul_Start,
   output logic             Illegal,
   output logic [2:0]       State,
   output logic [CNT_W-1:0] Instr_Count
);

   typedef enum logic [2:0] {
      S_FETCH    = 3'd0,
      S_DECODE   = 3'd1,
      S_ADDR     = 3'd2,
      S_EXEC     = 3'd3,
      S_MUL_WAIT = 3'd4,
      S_MEM_RD   = 3'd5,
      S_MEM_WR   = 3'd6,
      S_WB       = 3'd7
   } state_t;

   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

   state_t           state, state_nx;
   logic             trap, trap_nx;
   logic [5:0]       opcode, funct;
   logic [3:0]       mul_cnt, mul_cnt_nx;
   logic [CNT_W-1:0] count;
   logic             count_inc;
   logic             is_lw, is_sw, is_add, is_sub, is_mul;
   logic             unused_instr_bits;

   assign unused_instr_bits = ^mem.Instruction[25:6];

   assign is_lw  = (opcode == OP_LW);
   assign is_sw  = (opcode == OP_SW);
   assign is_add = (opcode == OP_RTYPE) && (funct == FN_ADD);
   assign is_sub = (opcode == OP_RTYPE) && (funct == FN_SUB);
   assign is_mul = (opcode == OP_RTYPE) && (funct == FN_MUL);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state   <= S_FETCH;
         trap    <= 1'b0;
         opcode  <= '0;
         funct   <= '0;
         mul_cnt <= '0;
         count   <= '0;
      end else begin
         state   <= state_nx;
         trap    <= trap_nx;
         mul_cnt <= mul_cnt_nx;
         if (!trap && state == S_FETCH && mem.Mem_Ready) begin
            opcode <= mem.Instruction[31:26];
            funct  <= mem.Instruction[5:0];
         end
         if (count_inc)
            count <= count + 1'b1;
      end
   end

   always_comb begin
      state_nx   = state;
      trap_nx    = trap;
      mul_cnt_nx = mul_cnt;
      count_inc  = 1'b0;
      if (!trap) begin
         case (state)
            S_FETCH:  if (mem.Mem_Ready) state_nx = S_DECODE;
            S_DECODE: begin
               if (is_lw || is_sw)
                  state_nx = S_ADDR;
               else if (is_add || is_sub)
                  state_nx = S_EXEC;
               else if (is_mul) begin
                  state_nx   = S_MUL_WAIT;
                  mul_cnt_nx = MUL_LOAD;
               end else begin
                  // Trap parks the FSM in FETCH; the sticky bit masks every output.
                  trap_nx  = 1'b1;
                  state_nx = S_FETCH;
               end
            end
            S_ADDR:   state_nx = is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (mem.Mem_Ready) state_nx = S_WB;
            S_MEM_WR: begin
               if (mem.Mem_Ready) begin
                  state_nx  = S_FETCH;
                  count_inc = 1'b1;
               end
            end
            S_EXEC:   state_nx = S_WB;
            S_MUL_WAIT: begin
               if (mul_cnt == 4'd0)
                  state_nx = S_WB;
               else
                  mul_cnt_nx = mul_cnt - 4'd1;
            end
            S_WB: begin
               state_nx  = S_FETCH;
               count_inc = 1'b1;
            end
            default:  state_nx = S_FETCH;
         endcase
      end
   end

   always_comb begin
      mem.Mem_Req   = 1'b0;
      mem.Mem_Write = 1'b0;
      IR_Write      = 1'b0;
      PC_Write      = 1'b0;
      ALU_Op        = 3'b000;
      ALU_SrcB      = 1'b0;
      RegDst        = 1'b0;
      MemToReg      = 1'b0;
      Reg_Write     = 1'b0;
      Mul_Start     = 1'b0;
      Illegal       = Rst_n && trap;
      State         = 3'd0;
      // Gate on Rst_n so FETCH's request strobes stay low while reset is held.
      if (Rst_n && !trap) begin
         State = state;
         case (state)
            S_FETCH: begin
               mem.Mem_Req = 1'b1;
               IR_Write    = mem.Mem_Ready;
               PC_Write    = mem.Mem_Ready;
            end
            S_ADDR:   ALU_SrcB = 1'b1;
            S_MEM_RD: mem.Mem_Req = 1'b1;
            S_MEM_WR: begin
               mem.Mem_Req   = 1'b1;
               mem.Mem_Write = 1'b1;
            end
            S_EXEC:   ALU_Op = is_sub ? 3'b001 : 3'b000;
            S_MUL_WAIT: begin
               ALU_Op    = 3'b010;
               Mul_Start = (mul_cnt == MUL_LOAD);
            end
            S_WB: begin
               Reg_Write = 1'b1;
               MemToReg  = is_lw;
               RegDst    = !is_lw;
               ALU_Op    = is_mul ? 3'b010 : (is_sub ? 3'b001 : 3'b000);
            end
            default: ;
         endcase
      end
   end

   assign Instr_Count = count;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed table-driven bench for multicycle_control
module tb_multicycle_control;

   logic       Clk;
   logic       Rst_n;
   logic       IR_Write, PC_Write, ALU_SrcB, RegDst, MemToReg, Reg_Write, Mul_Start, Illegal;
   logic [2:0] ALU_Op, State;
   logic [3:0] Instr_Count;

   multicycle_control_if mif();

   multicycle_control #(.MUL_CYCLES(4), .CNT_W(4)) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .mem         (mif),
      .IR_Write    (IR_Write),
      .PC_Write    (PC_Write),
      .ALU_Op      (ALU_Op),
      .ALU_SrcB    (ALU_SrcB),
      .RegDst      (RegDst),
      .MemToReg    (MemToReg),
      .Reg_Write   (Reg_Write),
      .Mul_Start   (Mul_Start),
      .Illegal     (Illegal),
      .State       (State),
      .Instr_Count (Instr_Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [31:0] ins;
      logic        rdy;
      logic [15:0] e;
      logic [3:0]  c;
   } vec_t;

   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;

   localparam logic [31:0] I_LW  = 32'h48015500;
   localparam logic [31:0] I_SW  = 32'h4C0758FF;
   localparam logic [31:0] I_ADD = 32'h44643020;
   localparam logic [31:0] I_SUB = 32'h44C53822;
   localparam logic [31:0] I_MUL = 32'h44453CB2;

   function automatic logic [15:0] ew(input logic [2:0] st, input logic req, input logic wr,
                                      input logic irw, input logic pcw, input logic [2:0] op,
                                      input logic srcb, input logic rd, input logic m2r,
                                      input logic rw, input logic ms, input logic ill);
      return {req, wr, irw, pcw, op, srcb, rd, m2r, rw, ms, ill, st};
   endfunction

   logic [15:0] act_w;
   assign act_w = {mif.Mem_Req, mif.Mem_Write, IR_Write, PC_Write, ALU_Op, ALU_SrcB,
                   RegDst, MemToReg, Reg_Write, Mul_Start, Illegal, State};

   logic [15:0] F_RDY, F_WAIT, DEC, ADDRW, MRD, MWR, WB_LW, EX_ADD, EX_SUB;
   logic [15:0] WB_ADD, WB_SUB, MW1, MWN, WB_MUL, TRAPW, ZERO;

   task automatic check(input string tag, input int idx, input logic [15:0] e, input logic [3:0] c);
      checks++;
      if (act_w !== e) begin
         failures++;
         $display("FAIL %s[%0d] outputs act=%h exp=%h", tag, idx, act_w, e);
      end
      checks++;
      if (Instr_Count !== c) begin
         failures++;
         $display("FAIL %s[%0d] Instr_Count act=%0d exp=%0d", tag, idx, Instr_Count, c);
      end
   endtask

   task automatic step(input string tag, input int idx, input logic [31:0] ins, input logic rdy,
                       input logic [15:0] e, input logic [3:0] c);
      @(negedge Clk);
      mif.Instruction = ins;
      mif.Mem_Ready   = rdy;
      #1;
      check(tag, idx, e, c);
   endtask

   task automatic do_reset(input string tag);
      @(negedge Clk);
      Rst_n         = 1'b0;
      mif.Mem_Ready = 1'b1;
      #1;
      check(tag, 0, ZERO, 4'd0);
      @(negedge Clk);
      #1;
      check(tag, 1, ZERO, 4'd0);
      Rst_n         = 1'b1;
      mif.Mem_Ready = 1'b0;
   endtask

   task automatic add_row(input logic [31:0] ins, input logic rdy, input logic [15:0] e, input logic [3:0] c);
      vec_t v;
      v.ins = ins; v.rdy = rdy; v.e = e; v.c = c;
      tbl.push_back(v);
   endtask

   initial begin
      F_RDY  = ew(3'd0, 1, 0, 1, 1, 3'd0, 0, 0, 0, 0, 0, 0);
      F_WAIT = ew(3'd0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
      DEC    = ew(3'd1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
      ADDRW  = ew(3'd2, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0);
      MRD    = ew(3'd5, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
      MWR    = ew(3'd6, 1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
      WB_LW  = ew(3'd7, 0, 0, 0, 0, 3'd0, 0, 0, 1, 1, 0, 0);
      EX_ADD = ew(3'd3, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
      EX_SUB = ew(3'd3, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 0);
      WB_ADD = ew(3'd7, 0, 0, 0, 0, 3'd0, 0, 1, 0, 1, 0, 0);
      WB_SUB = ew(3'd7, 0, 0, 0, 0, 3'd1, 0, 1, 0, 1, 0, 0);
      MW1    = ew(3'd4, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, 1, 0);
      MWN    = ew(3'd4, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, 0, 0);
      WB_MUL = ew(3'd7, 0, 0, 0, 0, 3'd2, 0, 1, 0, 1, 0, 0);
      TRAPW  = ew(3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1);
      ZERO   = 16'h0000;

      // LW, zero-wait memory
      add_row(I_LW, 1, F_RDY, 0);  add_row(I_LW, 1, DEC, 0);  add_row(I_LW, 1, ADDRW, 0);
      add_row(I_LW, 1, MRD, 0);    add_row(I_LW, 1, WB_LW, 0);
      // SW with three wait cycles in MEM_WR
      add_row(I_SW, 1, F_RDY, 1);  add_row(I_SW, 1, DEC, 1);  add_row(I_SW, 1, ADDRW, 1);
      add_row(I_SW, 0, MWR, 1);    add_row(I_SW, 0, MWR, 1);  add_row(I_SW, 0, MWR, 1);
      add_row(I_SW, 1, MWR, 1);
      // ADD preceded by one fetch wait, then SUB
      add_row(I_ADD, 0, F_WAIT, 2); add_row(I_ADD, 1, F_RDY, 2); add_row(I_ADD, 1, DEC, 2);
      add_row(I_ADD, 1, EX_ADD, 2); add_row(I_ADD, 1, WB_ADD, 2);
      add_row(I_SUB, 1, F_RDY, 3);  add_row(I_SUB, 1, DEC, 3);  add_row(I_SUB, 1, EX_SUB, 3);
      add_row(I_SUB, 1, WB_SUB, 3);
      // MUL with four MUL_WAIT cycles
      add_row(I_MUL, 1, F_RDY, 4);  add_row(I_MUL, 1, DEC, 4);  add_row(I_MUL, 1, MW1, 4);
      add_row(I_MUL, 1, MWN, 4);    add_row(I_MUL, 1, MWN, 4);  add_row(I_MUL, 1, MWN, 4);
      add_row(I_MUL, 1, WB_MUL, 4);
      // LW with one wait in MEM_RD
      add_row(I_LW, 1, F_RDY, 5);  add_row(I_LW, 1, DEC, 5);  add_row(I_LW, 1, ADDRW, 5);
      add_row(I_LW, 0, MRD, 5);    add_row(I_LW, 1, MRD, 5);  add_row(I_LW, 1, WB_LW, 5);
      add_row(I_LW, 0, F_WAIT, 6);

      Rst_n           = 1'b0;
      mif.Mem_Ready   = 1'b1;
      mif.Instruction = I_LW;
      #3;
      check("reset", 0, ZERO, 4'd0);
      @(negedge Clk);
      Rst_n         = 1'b1;
      mif.Mem_Ready = 1'b0;

      foreach (tbl[i])
         step("table", i, tbl[i].ins, tbl[i].rdy, tbl[i].e, tbl[i].c);

      // Illegal opcode: trapped for 20 cycles, count frozen
      step("trap_op", 0, 32'h0000_0000, 1, F_RDY, 6);
      step("trap_op", 1, 32'h0000_0000, 1, DEC, 6);
      for (int k = 0; k < 20; k++)
         step("trap_op_hold", k, 32'h0000_0000, 1, TRAPW, 6);
      do_reset("trap_op_clear");

      // Illegal R-format funct
      step("trap_fn", 0, 32'h4400_0001, 1, F_RDY, 0);
      step("trap_fn", 1, 32'h4400_0001, 1, DEC, 0);
      for (int k = 0; k < 20; k++)
         step("trap_fn_hold", k, 32'h4400_0001, 1, TRAPW, 0);
      do_reset("trap_fn_clear");
      step("trap_fn_resume", 0, I_ADD, 0, F_WAIT, 0);

      // Reset in the middle of MUL_WAIT aborts without a write-back or retire
      step("mul_abort", 0, I_MUL, 1, F_RDY, 0);
      step("mul_abort", 1, I_MUL, 1, DEC, 0);
      step("mul_abort", 2, I_MUL, 1, MW1, 0);
      step("mul_abort", 3, I_MUL, 1, MWN, 0);
      do_reset("mul_abort_rst");
      step("mul_abort_resume", 0, I_ADD, 1, F_RDY, 0);
      step("mul_abort_resume", 1, I_ADD, 1, DEC, 0);
      step("mul_abort_resume", 2, I_ADD, 1, EX_ADD, 0);
      step("mul_abort_resume", 3, I_ADD, 1, WB_ADD, 0);

      // 15 more ADDs: counter runs 1..15 then wraps to 0 on the 16th retire
      for (int n = 1; n < 16; n++) begin
         step("wrap", n, I_ADD, 1, F_RDY, 4'(n));
         step("wrap", n, I_ADD, 1, DEC, 4'(n));
         step("wrap", n, I_ADD, 1, EX_ADD, 4'(n));
         step("wrap", n, I_ADD, 1, WB_ADD, 4'(n));
      end
      step("wrap_zero", 0, I_ADD, 0, F_WAIT, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control unit for the MIPS CPU. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives one-hot-style datapath strobes.
- Generalises the single-cycle combinational decoder:
  - parametrised opcode/funct encodings;
  - a memory ready/request handshake with wait states;
  - a configurable multi-cycle MUL latency;
  - illegal-instruction trapping;
  - a retired-instruction counter.
- Sits between instruction memory / data memory and the register file / ALU datapath.

Parameters:
- OP_RTYPE, 6'b010001, opcode of R-format instructions
- OP_LW, 6'b010010, load word opcode
- OP_SW, 6'b010011, store word opcode
- FN_ADD, 6'b100000, R-format funct for ADD
- FN_SUB, 6'b100010, R-format funct for SUB
- FN_MUL, 6'b110010, R-format funct for MUL
- MUL_CYCLES, 4, cycles spent in MUL_WAIT (legal range 1..15)
- CNT_W, 16, width of the retired-instruction counter

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- Instruction  in  32  instruction word from instruction memory; valid when Mem_Ready=1 in FETCH
- Mem_Ready  in  1  memory completes the current request this cycle
- Mem_Req  out  1  memory request (fetch, load or store)
- Mem_Write  out  1  request is a store
- IR_Write  out  1  latch Instruction into the datapath IR
- PC_Write  out  1  PC <= PC+4
- ALU_Op  out  3  000 add, 001 sub, 010 mul
- ALU_SrcB  out  1  1 = sign-extended offset, 0 = register rt
- RegDst  out  1  1 = rd, 0 = rt
- MemToReg  out  1  1 = write-back data from memory
- Reg_Write  out  1  register file write enable
- Mul_Start  out  1  one-cycle pulse that starts the multiplier
- Illegal  out  1  sticky trap flag
- State  out  3  current state encoding (debug)
- Instr_Count  out  CNT_W  retired instructions, wrapping

Behaviour:
- Reset:
  - Rst_n=0 asynchronously forces state FETCH, clears Illegal, Instr_Count, the latched opcode/funct and the MUL counter.
  - All outputs are 0 while Rst_n=0.
  - Reset asserted mid-instruction aborts it with no Reg_Write.
- State encoding: FETCH=0, DECODE=1, ADDR=2, EXEC=3, MUL_WAIT=4, MEM_RD=5, MEM_WR=6, WB=7. TRAP is a separate sticky bit; State reads 0 while trapped.
- Output timing: Moore from registered state plus latched opcode/funct. The exceptions are IR_Write and PC_Write, which equal FETCH & Mem_Ready (same cycle). Outputs not listed for a state are 0.
- FETCH:
  - Mem_Req=1.
  - Holds indefinitely while Mem_Ready=0.
  - On Mem_Ready=1: IR_Write=PC_Write=1, latch Instruction[31:26] and [5:0], go to DECODE.
- DECODE: classify the latched opcode/funct:
  - OP_LW or OP_SW -> ADDR.
  - OP_RTYPE with FN_ADD or FN_SUB -> EXEC.
  - OP_RTYPE with FN_MUL -> MUL_WAIT, loading the counter with MUL_CYCLES-1.
  - Anything else -> TRAP.
- ADDR: ALU_Op=000, ALU_SrcB=1. Next state is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: Mem_Req=1; wait for Mem_Ready, then -> WB.
- MEM_WR:
  - Mem_Req=1, Mem_Write=1.
  - On Mem_Ready: Instr_Count+1, then -> FETCH.
- EXEC: ALU_Op=000 for ADD, 001 for SUB; ALU_SrcB=0. Then -> WB.
- MUL_WAIT:
  - ALU_Op=010 throughout.
  - Mul_Start=1 only in the first cycle of MUL_WAIT.
  - Counter decrements each cycle; leaves to WB in the cycle the counter reads 0. Total MUL_WAIT cycles = MUL_CYCLES.
- WB:
  - Reg_Write=1 for exactly one cycle.
  - LW: RegDst=0, MemToReg=1. R-format: RegDst=1, MemToReg=0, ALU_Op held.
  - Instr_Count+1, then -> FETCH.
- TRAP:
  - Illegal=1; no Mem_Req, Reg_Write, PC_Write or count increment.
  - Held until Rst_n=0.
- Latency with zero-wait memory (Mem_Ready=1 on first request):
  - ADD/SUB: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - MUL: 3+MUL_CYCLES cycles.
  - Each memory wait cycle adds 1.
- Instr_Count wraps from 2^CNT_W-1 to 0.
- Mem_Ready is ignored outside FETCH, MEM_RD and MEM_WR.

Test Plan:
1. Reset, then Instruction=32'h48015500 (LW), Mem_Ready=1 constant -> states 0,1,2,5,7. ALU_SrcB=1 in ADDR; in WB: Reg_Write=1, MemToReg=1, RegDst=0. Instr_Count=1.
2. Instruction=32'h4C0758FF (SW), with Mem_Ready held 0 for 3 cycles in MEM_WR -> Mem_Req=Mem_Write=1 for 4 cycles, Reg_Write never asserted, Instr_Count increments on exit.
3. ADD 32'h44643020, then SUB 32'h44C53822 -> EXEC ALU_Op=000 then 001, ALU_SrcB=0; WB RegDst=1, Reg_Write=1. Each instruction takes 4 cycles.
4. MUL 32'h44453CB2 with MUL_CYCLES=4 -> Mul_Start pulses once, 4 MUL_WAIT cycles with ALU_Op=010, then WB. Total 7 cycles.
5. Opcode 6'b000000, or R-format funct 6'b000001 -> Illegal=1 from the cycle after DECODE, all strobes 0 for the next 20 cycles; Rst_n pulse clears it and FETCH resumes.
6. Rst_n=0 during MUL_WAIT -> outputs 0 immediately, no Reg_Write; FETCH after release. With CNT_W=4, retire 16 instructions -> Instr_Count returns to 0.
